// File: rtl/bridge_sample_qualifier_pkg.sv
// Shared definitions for the bridge sample qualifier: qualifier state
// encoding, change counter width and saturation, and a saturating increment.
package bridge_sample_qualifier_pkg;

    // EMPTY: nothing qualified since reset. TRACK: cur_value holds a qualified value.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } qual_state_e;

    localparam int               CHG_CNT_W   = 16;
    localparam logic [CHG_CNT_W-1:0] CHG_CNT_MAX = 16'hFFFF;

    // Run counter width; STABLE_CYCLES is limited to 1..255.
    localparam int               RUN_W       = 8;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [CHG_CNT_W-1:0] chg_cnt_inc(input logic [CHG_CNT_W-1:0] v);
        return (v == CHG_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/qual_event_fifo.sv
// First-word-fall-through event queue for the bridge sample qualifier.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored, so push+pop on an empty queue is push only.
module qual_event_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  w_do_pop;
    logic                  w_do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; storage itself needs no reset since empty masks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write for accepted pushes.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/bridge_sample_qualifier.sv
// Bridge sample qualifier: accepts a bridged register value only after it has
// been sampled unchanged for STABLE_CYCLES consecutive clock edges, records
// each qualified change in an event queue and counts them.
// Optional feature macro: BRIDGE_QUAL_STALL_DETECT_EN enables the unsettled
// (stall) flag; without it unsettled is tied low and no stall counter exists.
//
// Event handshake: an event is offered while evt_valid is high with its value
// on evt_data; it is consumed at the clock edge where evt_valid && evt_ready,
// and evt_ready is ignored while evt_valid is low.
module bridge_sample_qualifier
    import bridge_sample_qualifier_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] cur_value,
    output logic                  cur_valid,
    output logic [DATA_WIDTH-1:0] evt_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CHG_CNT_W-1:0]  change_count,
    output logic                  overflow,
    output logic                  unsettled
);

    localparam logic [RUN_W-1:0] STABLE_L = RUN_W'(STABLE_CYCLES);

    // Elaboration-time parameter sanity checks.
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
        $error("STABLE_CYCLES must be in 1..255");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic [DATA_WIDTH-1:0] r_din_q;
    logic                  r_din_q_vld;
    logic [RUN_W-1:0]      r_run;
    logic [RUN_W-1:0]      w_run_next;
    logic                  w_sat;
    logic                  w_accept;
    qual_state_e           r_state;
    logic [DATA_WIDTH-1:0] r_cur_value;
    logic                  r_cur_valid;
    logic [CHG_CNT_W-1:0]  r_change_count;
    logic                  r_overflow;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;

    // A run only counts pairs of samples both taken since reset, so the first
    // post-reset acceptance always needs the full STABLE_CYCLES.
    always_comb begin
        w_run_next = '0;
        if (r_din_q_vld && (din == r_din_q)) begin
            w_run_next = (r_run == STABLE_L) ? r_run : r_run + 1'b1;
        end
    end

    // Acceptance fires on the edge where the run saturates; re-settling on the
    // value already held is not a change.
    assign w_sat    = (w_run_next == STABLE_L);
    assign w_accept = w_sat && ((r_state == ST_EMPTY) || (r_din_q != r_cur_value));

    // Input sampling register and run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_q     <= '0;
            r_din_q_vld <= 1'b0;
            r_run       <= '0;
        end else begin
            r_din_q     <= din;
            r_din_q_vld <= 1'b1;
            r_run       <= w_run_next;
        end
    end

    // Qualifier FSM with registered qualified value, valid flag and change count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_cur_value    <= '0;
            r_cur_valid    <= 1'b0;
            r_change_count <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state        <= ST_TRACK;
                        r_cur_value    <= r_din_q;
                        r_cur_valid    <= 1'b1;
                        r_change_count <= chg_cnt_inc(r_change_count);
                    end
                end
                ST_TRACK: begin
                    if (w_accept) begin
                        r_cur_value    <= r_din_q;
                        r_change_count <= chg_cnt_inc(r_change_count);
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign w_pop = evt_ready && !w_fifo_empty;

    // Sticky drop flag: an accepted change that found the queue full with no pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_accept && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    qual_event_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (r_din_q),
        .i_pop   (evt_ready),
        .o_data  (evt_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef BRIDGE_QUAL_STALL_DETECT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] TMO_L = STALL_W'(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_unsettled;

    // Counts edges since the run counter last saturated; flags after the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_unsettled <= 1'b0;
        end else if (w_sat) begin
            r_stall_cnt <= '0;
            r_unsettled <= 1'b0;
        end else begin
            if (r_stall_cnt != TMO_L) r_stall_cnt <= r_stall_cnt + 1'b1;
            r_unsettled <= (r_stall_cnt >= TMO_L - 1'b1);
        end
    end

    assign unsettled = r_unsettled;
`else
    assign unsettled = 1'b0;
`endif

    assign cur_value    = r_cur_value;
    assign cur_valid    = r_cur_valid;
    assign evt_valid    = !w_fifo_empty;
    assign change_count = r_change_count;
    assign overflow     = r_overflow;

endmodule
